// File: rtl/mim_ctrl_pkg.sv
// Shared definitions for the multicycle controller and the ALU control
// decoder: FSM state encoding, instruction opcodes, ALUOP codes and the
// datapath mux select encodings.
package mim_ctrl_pkg;

  // Controller states
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC_I  = 4'd3,
    ST_EXEC_R  = 4'd4,
    ST_ALU_WB  = 4'd5,
    ST_MEM_RD  = 4'd6,
    ST_LOAD_WB = 4'd7,
    ST_MEM_WR  = 4'd8,
    ST_JUMP    = 4'd9
  } state_e;

  // Instruction-register opcode field
  localparam logic [2:0] OP_ADDI  = 3'b000;
  localparam logic [2:0] OP_SUBI  = 3'b001;
  localparam logic [2:0] OP_ANDI  = 3'b010;
  localparam logic [2:0] OP_ORI   = 3'b011;
  localparam logic [2:0] OP_RTYPE = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_JUMP  = 3'b111;

  // ALUOP codes driven to the ALU control decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  // ALU B-operand mux selects
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_ONE = 2'b10;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // ALUOP for an immediate-form instruction; non-immediate opcodes fall
  // back to ADD, which is what address/PC arithmetic uses.
  function automatic logic [2:0] imm_aluop(input logic [2:0] op);
    case (op)
      OP_ADDI: imm_aluop = ALUOP_ADD;
      OP_SUBI: imm_aluop = ALUOP_SUB;
      OP_ANDI: imm_aluop = ALUOP_AND;
      OP_ORI:  imm_aluop = ALUOP_OR;
      default: imm_aluop = ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle CPU main controller. A single FSM sequences fetch, decode,
// execute, memory access and writeback. Outputs are decoded from the state
// only, except the handshake-completing strobes (ir_write, pc_write,
// instr_done) in the memory wait states, which fire in the mem_ready cycle.
module multicycle_controller
  import mim_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       instr_done
);

  state_e     state_q, state_d;
  // Opcode is only valid in DECODE, so it is held for EXEC_I's ALUOP.
  logic [2:0] opcode_q, opcode_d;

  // State and latched opcode registers; reset returns to IDLE at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= OP_ADDI;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state logic; memory states hold until mem_ready is seen.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_d = ST_EXEC_I;
          OP_RTYPE: state_d = ST_EXEC_R;
          OP_LOAD:  state_d = ST_MEM_RD;
          OP_STORE: state_d = ST_MEM_WR;
          default:  state_d = ST_JUMP;
        endcase
      end
      ST_EXEC_I:  state_d = ST_ALU_WB;
      ST_EXEC_R:  state_d = ST_ALU_WB;
      ST_ALU_WB:  state_d = ST_FETCH;
      ST_MEM_RD:  if (mem_ready) state_d = ST_LOAD_WB;
      ST_LOAD_WB: state_d = ST_FETCH;
      ST_MEM_WR:  if (mem_ready) state_d = ST_FETCH;
      ST_JUMP:    state_d = ST_FETCH;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode; everything not named in a state stays 0.
  always_comb begin
    alu_op     = ALUOP_ADD;
    alu_src_b  = SRCB_REG;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = PCSRC_ALU;
    instr_done = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_EXEC_I: begin
        alu_op    = imm_aluop(opcode_q);
        alu_src_b = SRCB_IMM;
      end
      ST_EXEC_R: begin
        alu_op    = ALUOP_RTYPE;
        alu_src_b = SRCB_REG;
      end
      ST_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_RD: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        alu_src_b  = SRCB_IMM;
        instr_done = mem_ready;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. The stimulus process drives
// opcode/mem_ready each cycle and queues the hand-computed output word for
// that cycle; a monitor on the falling edge pops and compares.
module tb_multicycle_controller;
  import mim_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic [1:0] alu_src_b;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic       reg_write, mem_to_reg, instr_done;
  logic [1:0] pc_src;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_b  (alu_src_b),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;

  // Word layout: alu_op[15:13] srcb[12:11] req we iord irw pcw rw m2r pcsrc[3:2] done [0] pad
  function automatic logic [15:0] w(input logic [2:0] aop, input logic [1:0] sb,
                                    input logic req, input logic we, input logic io,
                                    input logic irw, input logic pcw, input logic rw,
                                    input logic m2r, input logic [1:0] ps, input logic dn);
    w = {aop, sb, req, we, io, irw, pcw, rw, m2r, ps, dn, 1'b0};
  endfunction

  // Hand-written expected words per controller situation
  logic [15:0] E_ZERO, E_FETCH_WAIT, E_FETCH_GO, E_ALU_WB, E_EXEC_R, E_MEM_RD;
  logic [15:0] E_LOAD_WB, E_MEM_WR_WAIT, E_MEM_WR_GO, E_JUMP;

  initial begin
    E_ZERO        = w(3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    E_FETCH_WAIT  = w(3'b000, 2'b10, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    E_FETCH_GO    = w(3'b000, 2'b10, 1, 0, 0, 1, 1, 0, 0, 2'b00, 0);
    E_ALU_WB      = w(3'b000, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1);
    E_EXEC_R      = w(3'b111, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    E_MEM_RD      = w(3'b000, 2'b01, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    E_LOAD_WB     = w(3'b000, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'b00, 1);
    E_MEM_WR_WAIT = w(3'b000, 2'b01, 1, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    E_MEM_WR_GO   = w(3'b000, 2'b01, 1, 1, 1, 0, 0, 0, 0, 2'b00, 1);
    E_JUMP        = w(3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b10, 1);
  end

  function automatic logic [15:0] e_exec_i(input logic [2:0] aop);
    e_exec_i = w(aop, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endfunction

  // Monitor: compare the DUT outputs against the queued word mid-cycle
  always @(negedge clk) begin
    logic [15:0] got;
    exp_t        e;
    got = {alu_op, alu_src_b, mem_req, mem_we, iord, ir_write, pc_write,
           reg_write, mem_to_reg, pc_src, instr_done, 1'b0};
    if (instr_done === 1'b1) done_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got === e.word) begin
        n_pass++;
        $display("check %-12s ok   outputs=%h", e.name, got);
      end else begin
        $display("FAIL %s: outputs got %h expected %h", e.name, got, e.word);
      end
    end
  end

  // One controller cycle: drive inputs, queue expected word, advance
  task automatic step(input string nm, input logic [2:0] op, input logic mr,
                      input logic [15:0] exp_word);
    exp_t e;
    opcode    = op;
    mem_ready = mr;
    e.name = nm;
    e.word = exp_word;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = 3'b000;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("reset", 3'b000, 1'b1, E_ZERO);
    rst_n = 1'b1;
    step("idle", 3'b000, 1'b1, E_ZERO);

    // ADDI, zero wait; opcode changed after DECODE must not matter
    step("addi_fetch", 3'b111, 1'b1, E_FETCH_GO);
    step("addi_dec",   3'b000, 1'b1, E_ZERO);
    step("addi_exec",  3'b011, 1'b1, e_exec_i(3'b000));
    step("addi_wb",    3'b011, 1'b1, E_ALU_WB);

    // ORI
    step("ori_fetch", 3'b000, 1'b1, E_FETCH_GO);
    step("ori_dec",   3'b011, 1'b1, E_ZERO);
    step("ori_exec",  3'b000, 1'b1, e_exec_i(3'b011));
    step("ori_wb",    3'b000, 1'b1, E_ALU_WB);

    // R-type
    step("r_fetch", 3'b000, 1'b1, E_FETCH_GO);
    step("r_dec",   3'b100, 1'b1, E_ZERO);
    step("r_exec",  3'b000, 1'b1, E_EXEC_R);
    step("r_wb",    3'b000, 1'b1, E_ALU_WB);

    // LOAD with three wait cycles: 7 cycles in total
    step("ld_fetch", 3'b000, 1'b1, E_FETCH_GO);
    step("ld_dec",   3'b101, 1'b1, E_ZERO);
    step("ld_wait1", 3'b000, 1'b0, E_MEM_RD);
    step("ld_wait2", 3'b000, 1'b0, E_MEM_RD);
    step("ld_wait3", 3'b000, 1'b0, E_MEM_RD);
    step("ld_rdy",   3'b000, 1'b1, E_MEM_RD);
    step("ld_wb",    3'b000, 1'b1, E_LOAD_WB);

    // STORE then JUMP back-to-back
    step("st_fetch", 3'b000, 1'b1, E_FETCH_GO);
    step("st_dec",   3'b110, 1'b1, E_ZERO);
    step("st_wr",    3'b000, 1'b1, E_MEM_WR_GO);
    step("j_fetch",  3'b000, 1'b1, E_FETCH_GO);
    step("j_dec",    3'b111, 1'b1, E_ZERO);
    step("j_jump",   3'b000, 1'b1, E_JUMP);

    // FETCH stalls two cycles, then ANDI
    step("an_fwait1", 3'b000, 1'b0, E_FETCH_WAIT);
    step("an_fwait2", 3'b000, 1'b0, E_FETCH_WAIT);
    step("an_fetch",  3'b000, 1'b1, E_FETCH_GO);
    step("an_dec",    3'b010, 1'b1, E_ZERO);
    step("an_exec",   3'b000, 1'b1, e_exec_i(3'b010));
    step("an_wb",     3'b000, 1'b1, E_ALU_WB);

    // STORE stalled, then reset asserted between clock edges
    step("sr_fetch", 3'b000, 1'b1, E_FETCH_GO);
    step("sr_dec",   3'b110, 1'b1, E_ZERO);
    step("sr_wait",  3'b000, 1'b0, E_MEM_WR_WAIT);
    #1;
    rst_n = 1'b0;
    begin
      exp_t e;
      e.name = "async_rst";
      e.word = E_ZERO;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rs_idle",  3'b000, 1'b0, E_ZERO);
    step("rs_fetch", 3'b000, 1'b1, E_FETCH_GO);
    step("rs_dec",   3'b000, 1'b1, E_ZERO);
    step("rs_exec",  3'b000, 1'b1, e_exec_i(3'b000));
    step("rs_wb",    3'b000, 1'b1, E_ALU_WB);

    @(negedge clk);
    #1;
    // Eight instructions completed (the reset-aborted store does not count)
    n_checks++;
    if (done_cnt == 8) begin
      n_pass++;
      $display("check %-12s ok   count=%0d", "done_count", done_cnt);
    end else begin
      $display("FAIL done_count: instr_done pulses got %0d expected 8", done_cnt);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
      $display("check %-12s ok   pending=0", "queue_drain");
    end else begin
      $display("FAIL queue_drain: pending got %0d expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
